cacheline_adapter: RTL and testbench
====================================

Name: cacheline_adapter

Overview:
- Memory-side responder for the cache's physical-memory port.
- Accepts 256-bit line read/write requests (pmem_read/pmem_write, held until pmem_resp) from the cache.
- Serves each request as a 4-beat, 64-bit burst on a downstream burst-memory interface.
- Sits between the cache and main memory and owns the pmem_resp handshake.

Parameters:
- s_offset, 5, line offset bits; request address is aligned by clearing these bits.
- s_line, 256, line width in bits.
- s_beat, 64, burst beat width in bits.
- num_beats, s_line/s_beat (4), beats per line.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- pmem_address  in  32  line request address from cache
- pmem_wdata  in  256  line write data from cache
- pmem_read  in  1  line read request, held until pmem_resp
- pmem_write  in  1  line write request, held until pmem_resp
- pmem_resp  out  1  one-cycle completion pulse to cache
- pmem_rdata  out  256  assembled read line
- burst_address  out  32  aligned line address for downstream burst
- burst_read  out  1  downstream read burst request
- burst_write  out  1  downstream write burst request
- burst_wdata  out  64  current write beat
- burst_rdata  in  64  current read beat
- burst_resp  in  1  downstream beat accepted/valid, one per beat

Behaviour:
- Reset (rst low, asynchronous, any state, including mid-burst): state=IDLE, beat counter=0.
- Reset values of outputs: pmem_resp=0, pmem_rdata=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0. Outputs drop immediately, without waiting for clk.
- States: IDLE, READ, WRITE, RESP.
- IDLE, pmem_read=1: latch {pmem_address[31:s_offset], s_offset'b0} into burst_address; counter=0; go to READ.
- IDLE, pmem_write=1 and pmem_read=0: latch the aligned address and pmem_wdata into the line buffer; counter=0; go to WRITE.
- IDLE, both asserted: read wins. The write is not accepted and stays pending at the cache.
- IDLE: burst_resp is ignored.
- READ: burst_read=1, burst_address constant.
  - On each burst_resp=1, burst_rdata is written into line buffer bits [64*cnt+63 : 64*cnt] and the counter increments.
  - Beat 0 is the least significant.
  - On the beat with cnt=num_beats-1: counter wraps to 0, go to RESP.
- WRITE: burst_write=1, burst_wdata = line buffer [64*cnt+63 : 64*cnt].
  - On each burst_resp=1 the counter increments.
  - The last beat goes to RESP.
- Downstream stalls: burst_resp low for any number of cycles holds state, counter, burst_read/burst_write and burst_wdata stable. No timeout.
- RESP: pmem_resp=1 for exactly one cycle, burst_read=burst_write=0, then IDLE.
  - For a read, pmem_rdata equals the line buffer during RESP.
  - pmem_rdata holds its value until the next read overwrites the buffer. Writes do not disturb pmem_rdata.
- pmem_read/pmem_write in the RESP cycle are not sampled. A request is accepted only in IDLE, so a held request cannot be double-serviced.
- Latency with burst_resp always high:
  - accept at cycle T;
  - burst request asserted T+1..T+4;
  - pmem_resp at T+5.
- Back-to-back requests: the next request is accepted at T+6 at the earliest.
- pmem_address/pmem_wdata changes after acceptance do not affect the transaction in flight.

Test Plan:
- Reset: assert rst low mid-cycle with no clk edge -> all outputs 0 immediately; state IDLE after release.
- Read, pmem_address=0x0000_1234, beats 0x1111_1111_1111_1111, 0x2222…, 0x3333…, 0x4444… with burst_resp continuously high:
  - burst_address=0x0000_1220 on T+1..T+4;
  - pmem_resp only at T+5;
  - pmem_rdata = {0x4444…, 0x3333…, 0x2222…, 0x1111…}.
- Write, pmem_address=0x0000_00FF, pmem_wdata = {0xD…,0xC…,0xB…,0xA…}:
  - burst_address=0x0000_00E0;
  - burst_wdata sequence 0xA…, 0xB…, 0xC…, 0xD…;
  - pmem_resp one cycle after the 4th beat;
  - pmem_rdata unchanged.
- Stalled read with burst_resp pattern 1,0,0,1,0,1,1 -> beats captured only on high cycles; burst_read held through gaps; pmem_resp the cycle after the 4th high.
- pmem_read=pmem_write=1 in IDLE -> READ taken, burst_write stays 0; the write is serviced after the read completes and pmem_write remains asserted.
- rst low after 2 of 4 read beats -> burst_read=0 immediately, pmem_resp never pulses. After release, a new read completes normally with fresh data.

Source files
------------

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - cache line to 4-beat burst memory responder
module cacheline_adapter #(
    parameter int unsigned s_offset  = 5,
    parameter int unsigned s_line    = 256,
    parameter int unsigned s_beat    = 64,
    parameter int unsigned num_beats = s_line / s_beat
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_wdata,
    input  logic              pmem_read,
    input  logic              pmem_write,
    output logic              pmem_resp,
    output logic [s_line-1:0] pmem_rdata,
    output logic [31:0]       burst_address,
    output logic              burst_read,
    output logic              burst_write,
    output logic [s_beat-1:0] burst_wdata,
    input  logic [s_beat-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int unsigned cnt_w = (num_beats > 1) ? $clog2(num_beats) : 1;

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_read  = 2'd1;
    localparam logic [1:0] st_write = 2'd2;
    localparam logic [1:0] st_resp  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [cnt_w-1:0]  cnt;
    logic [31:0]       addr_q;
    logic [s_line-1:0] wr_line;
    logic [s_line-1:0] rd_line;

    logic accept_rd;
    logic accept_wr;
    logic beat_done;
    logic last_beat;

    // Offset bits of the request address are dropped by line alignment.
    logic unused_addr_bits;
    assign unused_addr_bits = ^pmem_address[s_offset-1:0];

    // Requests are sampled only in IDLE; a simultaneous read takes priority
    // and leaves the write pending at the cache.
    assign accept_rd = (state == st_idle) && pmem_read;
    assign accept_wr = (state == st_idle) && pmem_write && !pmem_read;
    assign beat_done = ((state == st_read) || (state == st_write)) && burst_resp;
    assign last_beat = beat_done && (cnt == cnt_w'(num_beats - 1));

    // Next-state selection for the request/burst/response sequence.
    always_comb begin
        state_next = state;
        case (state)
            st_idle: begin
                if (accept_rd) begin
                    state_next = st_read;
                end else if (accept_wr) begin
                    state_next = st_write;
                end
            end
            st_read: begin
                if (last_beat) begin
                    state_next = st_resp;
                end
            end
            st_write: begin
                if (last_beat) begin
                    state_next = st_resp;
                end
            end
            st_resp: begin
                state_next = st_idle;
            end
            default: begin
                state_next = st_idle;
            end
        endcase
    end

    // State register and beat counter; counter wraps to 0 on the last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= st_idle;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept_rd || accept_wr) begin
                cnt <= '0;
            end else if (beat_done) begin
                cnt <= last_beat ? '0 : cnt + cnt_w'(1);
            end
        end
    end

    // Line-aligned address and write line are captured once at acceptance so
    // later changes on the cache side cannot disturb the burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wr_line <= '0;
        end else begin
            if (accept_rd || accept_wr) begin
                addr_q <= {pmem_address[31:s_offset], {s_offset{1'b0}}};
            end
            if (accept_wr) begin
                wr_line <= pmem_wdata;
            end
        end
    end

    // Read beats fill the read line from the least significant beat upward;
    // it is separate from the write line so writes leave pmem_rdata intact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_line <= '0;
        end else if ((state == st_read) && burst_resp) begin
            rd_line[cnt*s_beat +: s_beat] <= burst_rdata;
        end
    end

    // Outputs decode directly from reset-cleared registers, so they fall
    // to zero as soon as reset asserts.
    always_comb begin
        pmem_resp     = (state == st_resp);
        pmem_rdata    = rd_line;
        burst_address = addr_q;
        burst_read    = (state == st_read);
        burst_write   = (state == st_write);
        burst_wdata   = wr_line[cnt*s_beat +: s_beat];
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - scoreboard bench for cacheline_adapter
`timescale 1ns/1ps
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  pmem_address = '0;
    logic [255:0] pmem_wdata = '0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata = '0;
    logic         burst_resp = 1'b0;

    cacheline_adapter dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_resp     (pmem_resp),
        .pmem_rdata    (pmem_rdata),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
    } beat_t;

    typedef struct {
        logic [255:0] line;
        int           cyc;
    } resp_t;

    beat_t exp_beat[$];
    resp_t exp_resp[$];
    beat_t eb;
    resp_t er;

    int total = 0;
    int bad = 0;
    logic [255:0] last_rd = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Beat monitor: every accepted downstream beat is matched against the queue.
    always @(negedge clk) begin
        if (rst && burst_resp && (burst_read || burst_write)) begin
            if (exp_beat.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beat_unexpected actual=beat at cycle %0d required=none", cyc);
            end else begin
                eb = exp_beat.pop_front();
                check("beat_read", 256'(burst_read), 256'(!eb.wr));
                check("beat_write", 256'(burst_write), 256'(eb.wr));
                check("beat_addr", 256'(burst_address), 256'(eb.addr));
                if (eb.wr) check("beat_wdata", 256'(burst_wdata), 256'(eb.wdata));
            end
        end
    end

    // Response monitor: each pmem_resp pulse is matched for data and cycle.
    always @(negedge clk) begin
        if (rst && pmem_resp) begin
            if (exp_resp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected actual=resp at cycle %0d required=none", cyc);
            end else begin
                er = exp_resp.pop_front();
                check("resp_rdata", pmem_rdata, er.line);
                check("resp_cycle", 256'(cyc), 256'(er.cyc));
            end
        end
    end

    task automatic push_beats(input bit wr, input logic [31:0] aligned, input logic [255:0] line);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.wr    = wr;
            b.addr  = aligned;
            b.wdata = line[k*64 +: 64];
            exp_beat.push_back(b);
        end
    endtask

    task automatic push_resp(input logic [255:0] line, input int c);
        resp_t r;
        r.line = line;
        r.cyc  = c;
        exp_resp.push_back(r);
    endtask

    // Downstream memory: drives burst_resp per pattern (then steady high)
    // until nb beats have been handed over; it returns the cycles spent.
    task automatic serve(input logic [255:0] line, input logic [15:0] pat, input int plen,
                         input int nb, output int it);
        int k;
        k  = 0;
        it = 0;
        while (k < nb && it < 200) begin
            burst_resp  = (it < plen) ? pat[it] : 1'b1;
            burst_rdata = line[k*64 +: 64];
            @(posedge clk);
            #1;
            if (burst_resp) k++;
            it++;
        end
        burst_resp  = 1'b0;
        burst_rdata = '0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] aligned,
                           input logic [255:0] line, input logic [15:0] pat, input int plen);
        int a;
        int it;
        push_beats(1'b0, aligned, '0);
        pmem_address = addr;
        pmem_read    = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        pmem_address = ~addr;
        serve(line, pat, plen, 4, it);
        push_resp(line, a + it);
        last_rd = line;
        @(posedge clk);
        #1;
        pmem_read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] aligned,
                            input logic [255:0] line);
        int a;
        int it;
        push_beats(1'b1, aligned, line);
        pmem_address = addr;
        pmem_wdata   = line;
        pmem_write   = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        pmem_address = ~addr;
        pmem_wdata   = ~line;
        serve('0, 16'hFFFF, 0, 4, it);
        push_resp(last_rd, a + it);
        @(posedge clk);
        #1;
        pmem_write = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pmem_resp"}, 256'(pmem_resp), 256'(0));
        check({tag, "_pmem_rdata"}, pmem_rdata, 256'(0));
        check({tag, "_burst_read"}, 256'(burst_read), 256'(0));
        check({tag, "_burst_write"}, 256'(burst_write), 256'(0));
        check({tag, "_burst_address"}, 256'(burst_address), 256'(0));
        check({tag, "_burst_wdata"}, 256'(burst_wdata), 256'(0));
    endtask

    initial begin
        int a;
        int it;
        logic [255:0] both_rd;
        logic [255:0] both_wr;

        // Power-up reset
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Plain read, burst_resp always high
        do_read(32'h0000_1234, 32'h0000_1220,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                16'hFFFF, 0);

        // Write; pmem_rdata must keep the previous read line
        do_write(32'h0000_00FF, 32'h0000_00E0,
                 {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});

        // Stalled read: burst_resp 1,0,0,1,0,1,1
        do_read(32'h0000_ABCD, 32'h0000_ABC0,
                {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555},
                16'h0069, 7);

        // Read and write asserted together: read first, write after
        both_rd = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                   64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
        both_wr = {64'hF000_0000_0000_0004, 64'hF000_0000_0000_0003,
                   64'hF000_0000_0000_0002, 64'hF000_0000_0000_0001};
        push_beats(1'b0, 32'h0000_0100, '0);
        push_beats(1'b1, 32'h0000_0100, both_wr);
        pmem_address = 32'h0000_0110;
        pmem_wdata   = both_wr;
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        serve(both_rd, 16'hFFFF, 0, 4, it);
        push_resp(both_rd, a + it);
        last_rd = both_rd;
        @(posedge clk);
        #1;
        pmem_read = 1'b0;
        @(posedge clk);
        #1;
        a = cyc;
        serve('0, 16'hFFFF, 0, 4, it);
        push_resp(both_rd, a + it);
        @(posedge clk);
        #1;
        pmem_write = 1'b0;

        // Asynchronous reset mid-cycle while idle with non-zero outputs
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("idle_async_reset");
        #1;
        rst = 1'b1;
        last_rd = '0;
        @(posedge clk);
        #1;

        // Reset after 2 of 4 read beats; no response may follow
        push_beats(1'b0, 32'h0000_2000, '0);
        pmem_address = 32'h0000_2008;
        pmem_read    = 1'b1;
        @(posedge clk);
        #1;
        serve({64'h0BAD_0000_0000_0004, 64'h0BAD_0000_0000_0003,
               64'h0BAD_0000_0000_0002, 64'h0BAD_0000_0000_0001},
              16'hFFFF, 0, 2, it);
        check("abort_beats_left", 256'(exp_beat.size()), 256'(2));
        #1;
        rst = 1'b0;
        #1;
        check("abort_burst_read", 256'(burst_read), 256'(0));
        check("abort_pmem_resp", 256'(pmem_resp), 256'(0));
        check("abort_pmem_rdata", pmem_rdata, 256'(0));
        pmem_read = 1'b0;
        exp_beat.delete();
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Fresh read after reset release
        do_read(32'h0000_3030, 32'h0000_3020,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h0F0F_0F0F_F0F0_F0F0, 64'h1234_5678_9ABC_DEF0},
                16'hFFFF, 0);

        // Held line must survive idle cycles
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", pmem_rdata, last_rd);
        check("beats_drained", 256'(exp_beat.size()), 256'(0));
        check("resps_drained", 256'(exp_resp.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
